// File: rtl/grs_reset_sequencer.sv
// Global reset sequencer: waits for stable PLL lock, holds GRS_N low,
// then releases GRS_N followed by staged domain resets in order.
module grs_reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned HOLD_CYCLES = 256,
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned STAGE_GAP   = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pll_lock,
    input  logic                  soft_rst_req,
    output logic                  grs_n,
    output logic [NUM_STAGES-1:0] sys_rstn,
    output logic                  rst_done,
    output logic [1:0]            rst_cause
);

    localparam int unsigned MAX_LH  = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_LH > STAGE_GAP) ? MAX_LH : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_STAGE     = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   rst_int_n;
    logic                   lock_s;
    logic                   abort;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_inc;
    logic [IDX_W-1:0]       idx_q;
    logic                   grs_n_q;
    logic [NUM_STAGES-1:0]  sys_rstn_q;
    logic                   rst_done_q;
    logic [1:0]             rst_cause_q;

    // Internal reset: asserted asynchronously, released after SYNC_STAGES edges
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // PLL lock synchronizer into the clk domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign rst_int_n = rst_sync_q[SYNC_STAGES-1];
    assign lock_s    = lock_sync_q[SYNC_STAGES-1];
    assign cnt_inc   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    // Lock loss only matters once the filter has accepted lock
    assign abort     = soft_rst_req || (!lock_s && (state_q != ST_WAIT_LOCK));

    // Sequencer FSM with registered reset outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            grs_n_q     <= 1'b0;
            sys_rstn_q  <= '0;
            rst_done_q  <= 1'b0;
            rst_cause_q <= CAUSE_POR;
        end else if (!rst_int_n) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            grs_n_q     <= 1'b0;
            sys_rstn_q  <= '0;
            rst_done_q  <= 1'b0;
            rst_cause_q <= CAUSE_POR;
        end else if (abort) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            grs_n_q     <= 1'b0;
            sys_rstn_q  <= '0;
            rst_done_q  <= 1'b0;
            rst_cause_q <= soft_rst_req ? CAUSE_SOFT : CAUSE_LOCK;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        grs_n_q <= 1'b1;
                        state_q <= ST_STAGE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_STAGE: begin
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        cnt_q             <= '0;
                        sys_rstn_q[idx_q] <= 1'b1;
                        if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                            rst_done_q <= 1'b1;
                            state_q    <= ST_RUN;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_q <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

    assign grs_n     = grs_n_q;
    assign sys_rstn  = sys_rstn_q;
    assign rst_done  = rst_done_q;
    assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_grs_reset_sequencer.sv
// Bench for grs_reset_sequencer: a time-based reference model predicts every
// output change; a monitor matches observed changes against that queue.
module tb_grs_reset_sequencer;

    localparam int unsigned SS  = 2;
    localparam int unsigned LF  = 16;
    localparam int unsigned HC  = 256;
    localparam int unsigned NS  = 3;
    localparam int unsigned GAP = 8;
    localparam int unsigned VW  = NS + 4;
    localparam int unsigned SEQ_MAX = LF + HC + NS * GAP + SS + 40;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          pll_lock = 1'b1;
    logic          soft_rst_req = 1'b0;
    logic          grs_n;
    logic [NS-1:0] sys_rstn;
    logic          rst_done;
    logic [1:0]    rst_cause;
    logic [VW-1:0] dut_vec;

    typedef struct {
        int unsigned   cyc;
        logic [VW-1:0] v;
    } ev_t;

    ev_t           exp_q[$];
    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    int unsigned   cyc = 0;
    bit            mon_en = 1'b0;

    // Reference model state
    logic [VW-1:0] m_prev = '0;
    bit            run_valid = 1'b0;
    int unsigned   run_start = 0;
    logic [1:0]    m_cause = 2'b00;
    int unsigned   age = 0;
    logic [SS-1:0] ph = '0;

    grs_reset_sequencer #(
        .SYNC_STAGES(SS), .LOCK_FILTER(LF), .HOLD_CYCLES(HC),
        .NUM_STAGES(NS), .STAGE_GAP(GAP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pll_lock    (pll_lock),
        .soft_rst_req(soft_rst_req),
        .grs_n       (grs_n),
        .sys_rstn    (sys_rstn),
        .rst_done    (rst_done),
        .rst_cause   (rst_cause)
    );

    assign dut_vec = {grs_n, sys_rstn, rst_done, rst_cause};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs from elapsed time since the current lock run began
    function automatic logic [VW-1:0] model_vec(input int unsigned n);
        logic          g;
        logic [NS-1:0] sr;
        int unsigned   base;
        g    = 1'b0;
        sr   = '0;
        base = run_start + LF - 1 + HC;
        if (run_valid) begin
            g = (n >= base);
            for (int i = 0; i < NS; i++) sr[i] = (n >= base + (i + 1) * GAP);
        end
        return {g, sr, sr[NS-1], m_cause};
    endfunction

    task automatic push_exp(input int unsigned tag, input logic [VW-1:0] v);
        ev_t e;
        if (v !== m_prev) begin
            if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == tag) begin
                exp_q[exp_q.size()-1].v = v;
            end else begin
                e.cyc = tag;
                e.v   = v;
                exp_q.push_back(e);
            end
            m_prev = v;
        end
    endtask

    // Reference model: reset assertion is modelled when clk is low, edges when high
    initial begin : model
        logic ls;
        forever begin
            @(posedge clk or negedge rstn);
            if (!clk) begin
                run_valid = 1'b0; m_cause = 2'b00; age = 0; ph = '0;
                push_exp(cyc + 1, model_vec(cyc + 1));
            end else begin
                cyc++;
                if (!rstn) begin
                    run_valid = 1'b0; m_cause = 2'b00; age = 0; ph = '0;
                end else begin
                    ls = ph[SS-1];
                    ph = {ph[SS-2:0], pll_lock};
                    if (age >= SS) begin
                        if (soft_rst_req) begin
                            m_cause   = 2'b10;
                            run_valid = 1'b0;
                        end else if (!ls) begin
                            if (run_valid && cyc >= run_start + LF) m_cause = 2'b01;
                            run_valid = 1'b0;
                        end else if (!run_valid) begin
                            run_valid = 1'b1;
                            run_start = cyc;
                        end
                    end else begin
                        age++;
                    end
                end
                push_exp(cyc, model_vec(cyc));
            end
        end
    end

    // Monitor: every observed output change must match the next predicted one
    initial begin : monitor
        logic [VW-1:0] prev;
        ev_t           e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mon_en && dut_vec !== prev) begin
                check("evt_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("evt_value", 32'(dut_vec), 32'(e.v));
                    check("evt_cycle", cyc, e.cyc);
                end
                prev = dut_vec;
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_soft();
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int unsigned k;
        k = 0;
        while (rst_done !== 1'b1 && k < SEQ_MAX) begin
            tick(1);
            k++;
        end
        check(name, 32'(rst_done), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned k;
        int unsigned r;
        #1 rstn = 1'b0;
        tick(3);
        mon_en = 1'b1;
        check("reset_state", 32'(dut_vec), 32'd0);

        // Power-on with stable lock
        rstn = 1'b1;
        wait_done("por_done");
        check("por_cause", 32'(rst_cause), 32'd0);
        check("por_all_released", 32'(dut_vec), 32'({1'b1, {NS{1'b1}}, 1'b1, 2'b00}));

        // Lock glitch inside the filter window after a lock loss
        pll_lock = 1'b0; tick(4);
        pll_lock = 1'b1; tick(10);
        pll_lock = 1'b0; tick(1);
        pll_lock = 1'b1;
        wait_done("glitch_done");
        check("glitch_cause", 32'(rst_cause), 32'd1);

        // Lock loss in RUN then restore
        pll_lock = 1'b0;
        tick(SS + 1);
        check("lockloss_out", 32'(dut_vec), 32'd1);
        pll_lock = 1'b1;
        wait_done("lockloss_done");

        // Soft request after the first domain release
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        check("soft_in_run", 32'(dut_vec), 32'd2);
        k = 0;
        while (sys_rstn[0] !== 1'b1 && k < SEQ_MAX) begin tick(1); k++; end
        check("stage0_seen", 32'(sys_rstn), 32'd1);
        pulse_soft();
        check("soft_mid_stage", 32'(dut_vec), 32'd2);
        wait_done("soft_done");

        // Lock loss and soft request hitting the same edge
        pll_lock = 1'b0;
        tick(SS);
        pulse_soft();
        check("simul_out", 32'(dut_vec), 32'd2);
        pll_lock = 1'b1;
        wait_done("simul_done");

        // Async reset in HOLD
        pulse_soft();
        tick(LF + SS + 100);
        #2 rstn = 1'b0;
        #1 check("async_reset", 32'(dut_vec), 32'd0);
        tick(3);
        rstn = 1'b1;
        wait_done("async_done");
        check("async_cause", 32'(rst_cause), 32'd0);

        // Randomized disturbances
        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: begin pll_lock = 1'b0; tick($urandom_range(1, 6)); pll_lock = 1'b1; end
                1: pulse_soft();
                2: begin pll_lock = 1'b0; tick(1); pll_lock = 1'b1; end
                3: begin pll_lock = 1'b0; tick(SS); pulse_soft(); pll_lock = 1'b1; end
                default: tick(1);
            endcase
            tick($urandom_range(1, 350));
        end

        pll_lock = 1'b1;
        wait_done("final_done");
        tick(3);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
